regfile_rw_responder: RTL
=========================

# regfile_rw_responder

Register-file responder for the functional-unit (FU) register-access protocol. It holds the architectural registers and answers FU read requests with operand values one cycle later. It tracks per-register write-pending (busy) bits so RAW and WAW hazards are enforced at read time, and it retires FU write-backs. It sits between one FU's read and write-back ports and the register storage; write-after-read ordering stays with the scoreboard.

## Interface
Parameters:
- NUM_REG, 8: number of architectural registers.
- REG_BIT, 16: register width.
- INST_ID_BIT, 8: instruction id width. Used for debug and error capture only.
- REG_ID_BIT, $clog2(NUM_REG): register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- read_req_vld  in  1  FU read request valid.
- read_req_rdy  out  1  request accepted when vld && rdy.
- read_reg0_id  in  REG_ID_BIT  source operand 0 index.
- read_reg1_id  in  REG_ID_BIT  source operand 1 index.
- write_reg_id_nxt  in  REG_ID_BIT  destination register; marked busy on accept.
- read_fbk_vld  out  1  operand values valid.
- read_fbk_rdy  in  1  FU consumes operands.
- read_reg0_val  out  REG_BIT  value of read_reg0_id.
- read_reg1_val  out  REG_BIT  value of read_reg1_id.
- write_back_vld  in  1  FU result valid.
- write_back_rdy  out  1  tied to 1.
- write_back_id  in  INST_ID_BIT  instruction id of the result.
- write_back_reg_id  in  REG_ID_BIT  destination register of the result.
- write_back_val  in  REG_BIT  result value.
- busy_mask  out  NUM_REG  write-pending bit per register.
- err_wb_not_busy  out  1  sticky; set by a write-back to a non-busy register.
- err_id  out  INST_ID_BIT  write_back_id of the first erroneous write-back.
- idle  out  1  no busy bits set and no feedback pending.

## Operation
- State held:
  - regs[NUM_REG], reset to 0.
  - busy[NUM_REG], reset to 0.
  - One-entry feedback register: fbk_vld plus two values.
- Write-back is accepted every cycle it is valid:
  - regs[write_back_reg_id] <= write_back_val.
  - busy[write_back_reg_id] <= 0.
- Effective busy for this cycle: busy_eff = busy with the bit for the same-cycle write-back register cleared.
- read_req_rdy = !busy_eff[read_reg0_id] && !busy_eff[read_reg1_id] && !busy_eff[write_reg_id_nxt] && (!fbk_vld || read_fbk_rdy).
  - rdy does not depend on read_req_vld.
- On an accepted request:
  - Operand values are captured into the feedback register. If the same-cycle write-back targets a source register, the write-back value is forwarded.
  - busy[write_reg_id_nxt] <= 1.
  - fbk_vld <= 1.
- Self-reference (dst == src, e.g. r3 = add r3,r2): the source is read with its old value. The busy bit is set after the check, so the request is not blocked by its own destination.
- Feedback: fbk_vld clears on read_fbk_rdy unless a new request is accepted in the same cycle. Values hold stable while vld && !rdy.
- Same-cycle write-back to register R plus a new accept with destination R: busy[R] ends at 1; the set wins over the clear.
- Write-back to a register whose busy bit is 0:
  - The write is still performed.
  - err_wb_not_busy is set and err_id captures write_back_id, first occurrence only.
- busy_mask is the registered busy bits.
- idle = (busy == 0) && !fbk_vld.

## Timing
- Request accepted in cycle t: read_fbk_vld is high from t+1, with values as of t including forwarding.
- Back-to-back accepts every cycle are possible when read_fbk_rdy is held high.
- Write-back in cycle t:
  - The value is visible to a request in cycle t through forwarding.
  - busy_mask drops at t+1.
- Write-back latency from the FU's view is zero (write_back_rdy = 1).
- Reset mid-operation: all regs, busy bits, fbk_vld and the error flag clear asynchronously. Outputs read 0 from reset assertion.

## Structure
- Shared package: REG_ID_BIT derivation and default widths, common with the FU and the scoreboard.
- Sub-module: the existing decode (one-hot) for the destination set mask and the write-back clear mask.
- Everything else is flat: storage array, busy vector, feedback register, error capture.

## Test plan
- After reset, read r1, r2 with all regs 0 -> rdy=1; read_fbk_vld at t+1 with 0, 0; busy_mask = 8'b0000_0100 (dst r2).
- Write-back r2 = 0x1234 while busy[r2] = 1, then read r2 the next cycle -> operand 0x1234; busy_mask bit 2 clears one cycle after the write-back.
- RAW: request reading r4 while busy[r4] = 1 -> rdy=0 until a write-back of r4 = 0x00AA. In that same cycle rdy=1 and the operand is forwarded as 0x00AA.
- Self-reference: r3 = 5, request src r3 / dst r3 -> accepted; operand 5; busy[3] = 1. An immediate second request reading r3 -> rdy=0.
- Feedback backpressure: read_fbk_rdy = 0 for 3 cycles -> values stable and no new accept. When rdy rises, the next request is accepted in the same cycle.
- Write-back to r6 with busy[6] = 0 and id 0x2A -> regs[6] written; err_wb_not_busy = 1 and err_id = 0x2A. A later error leaves err_id at 0x2A. Reset clears both.

Source files
------------

// File: rtl/regfile_rw_responder_pkg.sv
// rtl/regfile_rw_responder_pkg.sv - shared register-file widths and index-width helper
package regfile_rw_responder_pkg;

    localparam int NUM_REG_DEF     = 8;
    localparam int REG_BIT_DEF     = 16;
    localparam int INST_ID_BIT_DEF = 8;

    // Keeps a single-register file from collapsing to a zero-width index.
    function automatic int reg_id_bits(input int num_reg);
        return (num_reg <= 1) ? 1 : $clog2(num_reg);
    endfunction

endpackage

// File: rtl/regfile_rw_responder_if.sv
// rtl/regfile_rw_responder_if.sv - FU read-request, operand-feedback and write-back bundle
interface regfile_rw_responder_if
    import regfile_rw_responder_pkg::*;
#(
    parameter int NUM_REG     = NUM_REG_DEF,
    parameter int REG_BIT     = REG_BIT_DEF,
    parameter int INST_ID_BIT = INST_ID_BIT_DEF,
    parameter int REG_ID_BIT  = reg_id_bits(NUM_REG)
);

    logic                   read_req_vld;
    logic                   read_req_rdy;
    logic [REG_ID_BIT-1:0]  read_reg0_id;
    logic [REG_ID_BIT-1:0]  read_reg1_id;
    logic [REG_ID_BIT-1:0]  write_reg_id_nxt;
    logic                   read_fbk_vld;
    logic                   read_fbk_rdy;
    logic [REG_BIT-1:0]     read_reg0_val;
    logic [REG_BIT-1:0]     read_reg1_val;
    logic                   write_back_vld;
    logic                   write_back_rdy;
    logic [INST_ID_BIT-1:0] write_back_id;
    logic [REG_ID_BIT-1:0]  write_back_reg_id;
    logic [REG_BIT-1:0]     write_back_val;

    modport master (
        output read_req_vld, read_reg0_id, read_reg1_id, write_reg_id_nxt,
        output read_fbk_rdy,
        output write_back_vld, write_back_id, write_back_reg_id, write_back_val,
        input  read_req_rdy, read_fbk_vld, read_reg0_val, read_reg1_val,
        input  write_back_rdy
    );

    modport slave (
        input  read_req_vld, read_reg0_id, read_reg1_id, write_reg_id_nxt,
        input  read_fbk_rdy,
        input  write_back_vld, write_back_id, write_back_reg_id, write_back_val,
        output read_req_rdy, read_fbk_vld, read_reg0_val, read_reg1_val,
        output write_back_rdy
    );

endinterface

// File: rtl/regfile_rw_responder_dec.sv
// rtl/regfile_rw_responder_dec.sv - enabled one-hot decode of a register index
module regfile_rw_responder_dec #(
    parameter int NUM_REG    = 8,
    parameter int REG_ID_BIT = 3
) (
    input  logic                  en,
    input  logic [REG_ID_BIT-1:0] idx,
    output logic [NUM_REG-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        // Indices past NUM_REG decode to nothing on non-power-of-two files.
        if (en && (int'(idx) < NUM_REG)) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_rw_responder.sv
// rtl/regfile_rw_responder.sv - register file with busy tracking, operand forwarding and write-back retire
module regfile_rw_responder
    import regfile_rw_responder_pkg::*;
#(
    parameter int NUM_REG     = NUM_REG_DEF,
    parameter int REG_BIT     = REG_BIT_DEF,
    parameter int INST_ID_BIT = INST_ID_BIT_DEF,
    parameter int REG_ID_BIT  = reg_id_bits(NUM_REG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_rw_responder_if.slave  fu,
    output logic [NUM_REG-1:0]     busy_mask,
    output logic                   err_wb_not_busy,
    output logic [INST_ID_BIT-1:0] err_id,
    output logic                   idle
);

    logic [REG_BIT-1:0]     regs [NUM_REG];
    logic [NUM_REG-1:0]     busy;
    logic [NUM_REG-1:0]     busy_eff;
    logic [NUM_REG-1:0]     set_mask;
    logic [NUM_REG-1:0]     clr_mask;
    logic                   wb_vld;
    logic [REG_ID_BIT-1:0]  wb_reg;
    logic [REG_ID_BIT-1:0]  src0_id;
    logic [REG_ID_BIT-1:0]  src1_id;
    logic [REG_ID_BIT-1:0]  dst_id;
    logic [REG_BIT-1:0]     src0_val;
    logic [REG_BIT-1:0]     src1_val;
    logic                   req_rdy;
    logic                   accept;
    logic                   fbk_vld;
    logic [REG_BIT-1:0]     fbk_val0;
    logic [REG_BIT-1:0]     fbk_val1;
    logic                   err_flag;
    logic [INST_ID_BIT-1:0] err_id_q;

    assign wb_vld  = fu.write_back_vld;
    assign wb_reg  = fu.write_back_reg_id;
    assign src0_id = fu.read_reg0_id;
    assign src1_id = fu.read_reg1_id;
    assign dst_id  = fu.write_reg_id_nxt;

    regfile_rw_responder_dec #(
        .NUM_REG    (NUM_REG),
        .REG_ID_BIT (REG_ID_BIT)
    ) u_clr_dec (
        .en     (wb_vld),
        .idx    (wb_reg),
        .onehot (clr_mask)
    );

    regfile_rw_responder_dec #(
        .NUM_REG    (NUM_REG),
        .REG_ID_BIT (REG_ID_BIT)
    ) u_set_dec (
        .en     (accept),
        .idx    (dst_id),
        .onehot (set_mask)
    );

    // A same-cycle write-back releases its register before the hazard check.
    assign busy_eff = busy & ~clr_mask;
    assign req_rdy  = !busy_eff[src0_id] && !busy_eff[src1_id] && !busy_eff[dst_id]
                      && (!fbk_vld || fu.read_fbk_rdy);
    assign accept   = fu.read_req_vld && req_rdy;

    assign src0_val = (wb_vld && (wb_reg == src0_id)) ? fu.write_back_val : regs[src0_id];
    assign src1_val = (wb_vld && (wb_reg == src1_id)) ? fu.write_back_val : regs[src1_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_vld) begin
            regs[wb_reg] <= fu.write_back_val;
        end
    end

    // Destination set is ORed after the clear so a same-register accept wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbk_vld  <= 1'b0;
            fbk_val0 <= '0;
            fbk_val1 <= '0;
        end else if (accept) begin
            fbk_vld  <= 1'b1;
            fbk_val0 <= src0_val;
            fbk_val1 <= src1_val;
        end else if (fu.read_fbk_rdy) begin
            fbk_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_id_q <= '0;
        end else if (wb_vld && ((busy & clr_mask) == '0) && !err_flag) begin
            err_flag <= 1'b1;
            err_id_q <= fu.write_back_id;
        end
    end

    assign fu.read_req_rdy   = req_rdy;
    assign fu.read_fbk_vld   = fbk_vld;
    assign fu.read_reg0_val  = fbk_val0;
    assign fu.read_reg1_val  = fbk_val1;
    assign fu.write_back_rdy = 1'b1;

    assign busy_mask       = busy;
    assign err_wb_not_busy = err_flag;
    assign err_id          = err_id_q;
    assign idle            = (busy == '0) && !fbk_vld;

endmodule
